// File: rtl/instr_encoder_loader_pkg.sv
// Shared ISA definitions for the instruction encoder/loader: op classes, opcodes,
// loader states and the field-to-word packing function.
package instr_encoder_loader_pkg;

    typedef enum logic [3:0] {
        OP_R_TYPE = 4'd0,
        OP_ADDI   = 4'd1,
        OP_SLTIU  = 4'd2,
        OP_BEQ    = 4'd3,
        OP_LUI    = 4'd4,
        OP_ORI    = 4'd5,
        OP_BNE    = 4'd6,
        OP_LW     = 4'd7,
        OP_SW     = 4'd8,
        OP_BLT    = 4'd9,
        OP_BGT    = 4'd10,
        OP_JRS    = 4'd11,
        OP_J      = 4'd12,
        OP_JAL    = 4'd13
    } op_sel_e;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_BNE     = 6'h05;
    localparam logic [5:0] OPC_ADDI    = 6'h08;
    localparam logic [5:0] OPC_SLTIU   = 6'h0B;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_SW      = 6'h2B;
    localparam logic [5:0] FUNCT_JR    = 6'h08;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } load_state_e;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_result_t;

    function automatic enc_result_t encode_instr(
        input logic [3:0]  op_sel,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        enc_result_t r;
        r.legal = 1'b1;
        r.word  = '0;
        case (op_sel)
            OP_R_TYPE: r.word = {OPC_SPECIAL, rs, rt, rd, shamt, funct};
            OP_ADDI:   r.word = {OPC_ADDI, rs, rt, imm};
            OP_SLTIU:  r.word = {OPC_SLTIU, rs, rt, imm};
            OP_BEQ:    r.word = {OPC_BEQ, rs, rt, imm};
            OP_LUI:    r.word = {OPC_LUI, 5'd0, rt, imm};
            OP_ORI:    r.word = {OPC_ORI, rs, rt, imm};
            OP_BNE:    r.word = {OPC_BNE, rs, rt, imm};
            OP_LW:     r.word = {OPC_LW, rs, rt, imm};
            OP_SW:     r.word = {OPC_SW, rs, rt, imm};
            OP_JRS:    r.word = {OPC_SPECIAL, rs, 15'd0, FUNCT_JR};
            OP_J:      r.word = {OPC_J, target};
            OP_JAL:    r.word = {OPC_JAL, target};
            // BLT/BGT have no native MIPS encoding; they and codes 14/15 are rejected
            default:   r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_enc_fifo.sv
// Small synchronous FIFO holding encoded words; the head entry comes straight
// from a storage register so the memory port sees a glitch-free word.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [DEPTH-1:0] slot_we;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, do_pop};

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
        assign slot_we[gi] = do_push && (wr_ptr_q[PTR_W-1:0] == PTR_W'(gi));
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_we[i]) begin
                    slot_q[i] <= data_i;
                end
            end
        end
    end

    assign head_o = slot_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs instruction fields into MIPS words and streams them through a FIFO into
// instruction memory at consecutive word addresses, one load session at a time.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        load_start_i,
    input  logic        load_end_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [3:0]  op_sel_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic        mem_we_o,
    input  logic        mem_wready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [15:0] instr_cnt_o,
    output logic        err_o,
    output logic        wrap_o,
    output logic        done_o
);
    localparam int              IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MEM_WORDS - 1);

    load_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    enc_result_t      enc;
    logic             accept;
    logic             push;
    logic             wr_fire;
    logic             fifo_full;
    logic             fifo_empty;
    logic [31:0]      fifo_head;

    assign enc = encode_instr(op_sel_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i);

    // A pop in the same cycle does not open a slot for the producer
    assign in_ready_o = (state_q == ST_LOAD) & ~fifo_full;
    assign accept     = in_valid_i & in_ready_o;
    assign push       = accept & enc.legal;
    assign mem_we_o   = ~fifo_empty & (state_q != ST_IDLE);
    assign wr_fire    = mem_we_o & mem_wready_i;

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (enc.word),
        .pop_i   (wr_fire),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = wrap_q;
        err_d   = accept & ~enc.legal;
        done_d  = 1'b0;

        if (wr_fire) begin
            if (idx_q == IDX_LAST) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (load_start_i) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    cnt_d   = '0;
                    wrap_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (load_end_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Address and data are forced to zero whenever no write is requested
    assign mem_addr_o  = mem_we_o ? (BASE_ADDR + (32'(idx_q) << 2)) : 32'd0;
    assign mem_data_o  = mem_we_o ? fifo_head : 32'd0;
    assign instr_cnt_o = cnt_q;
    assign err_o       = err_q;
    assign wrap_o      = wrap_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed and random sessions against a queue-based
// model; a second instance with a 4-word memory exercises index wrap-around.
module tb_instr_encoder_loader;

    localparam int DEPTH = 4;
    localparam int WRAP_WORDS = 4;
    localparam logic [31:0] WRAP_BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start_i, load_end_i, in_valid_i, mem_wready_i;
    logic [3:0]  op_sel_i;
    logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
    logic [5:0]  funct_i;
    logic [15:0] imm_i;
    logic [25:0] target_i;

    logic        in_ready_o, mem_we_o, err_o, wrap_o, done_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [15:0] instr_cnt_o;
    logic        w_in_ready, w_mem_we, w_err, w_wrap, w_done;
    logic [31:0] w_mem_addr, w_mem_data;
    logic [15:0] w_instr_cnt;

    int errors = 0;
    int checks = 0;

    // model state: 0 idle, 1 loading, 2 draining
    int          mstate;
    logic [31:0] q[$];
    logic [31:0] lit_q[$];
    int          writes;
    bit          perr, pdone, acc_g, rand_wr;

    always #5 clk = ~clk;

    instr_encoder_loader #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n(rst_n), .load_start_i(load_start_i), .load_end_i(load_end_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .op_sel_i(op_sel_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .shamt_i(shamt_i), .funct_i(funct_i),
        .imm_i(imm_i), .target_i(target_i), .mem_we_o(mem_we_o), .mem_wready_i(mem_wready_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .instr_cnt_o(instr_cnt_o),
        .err_o(err_o), .wrap_o(wrap_o), .done_o(done_o)
    );

    instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(WRAP_BASE), .MEM_WORDS(WRAP_WORDS)) dut_w (
        .clk_i(clk), .rst_n(rst_n), .load_start_i(load_start_i), .load_end_i(load_end_i),
        .in_valid_i(in_valid_i), .in_ready_o(w_in_ready), .op_sel_i(op_sel_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .shamt_i(shamt_i), .funct_i(funct_i),
        .imm_i(imm_i), .target_i(target_i), .mem_we_o(w_mem_we), .mem_wready_i(mem_wready_i),
        .mem_addr_o(w_mem_addr), .mem_data_o(w_mem_data), .instr_cnt_o(w_instr_cnt),
        .err_o(w_err), .wrap_o(w_wrap), .done_o(w_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_encode(input int op, input int rs, input int rt, input int rd,
                                      input int sh, input int fn, input int imm, input int tg,
                                      output logic [31:0] w);
        longint unsigned v;
        int opc;
        w = '0;
        v = 0;
        case (op)
            1: opc = 'h08;  2: opc = 'h0B;  3: opc = 'h04;  4: opc = 'h0F;
            5: opc = 'h0D;  6: opc = 'h05;  7: opc = 'h23;  8: opc = 'h2B;
            default: opc = -1;
        endcase
        if (op == 0)
            v = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + longint'(sh) * 64 + longint'(fn);
        else if (op == 11)
            v = longint'(rs) * 2097152 + 8;
        else if (op == 12 || op == 13)
            v = longint'(op - 10) * 67108864 + longint'(tg);
        else if (opc >= 0)
            v = longint'(opc) * 67108864 + longint'(op == 4 ? 0 : rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
        else
            return 1'b0;
        w = v[31:0];
        return 1'b1;
    endfunction

    task automatic model_reset();
        mstate = 0;
        q.delete();
        writes = 0;
        perr = 0;
        pdone = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, 32'(in_ready_o), 0);
        chk({tag, "_we"}, 32'(mem_we_o), 0);
        chk({tag, "_addr"}, mem_addr_o, 0);
        chk({tag, "_data"}, mem_data_o, 0);
        chk({tag, "_cnt"}, 32'(instr_cnt_o), 0);
        chk({tag, "_err"}, 32'(err_o), 0);
        chk({tag, "_wrap"}, 32'(wrap_o), 0);
        chk({tag, "_done"}, 32'(done_o), 0);
        chk({tag, "_w_we"}, 32'(w_mem_we), 0);
        chk({tag, "_w_addr"}, w_mem_addr, 0);
    endtask

    // One clock: check outputs at the falling edge, advance the model, return just after the rising edge
    task automatic cycle();
        bit          exp_ready, exp_we, legal, was_empty;
        logic [31:0] w, head;
        int          cnt_exp;
        @(negedge clk);
        exp_ready = (mstate == 1) && (q.size() < DEPTH);
        exp_we    = (q.size() != 0) && (mstate != 0);
        was_empty = (q.size() == 0);
        cnt_exp   = (writes > 65535) ? 65535 : writes;
        chk("in_ready", 32'(in_ready_o), 32'(exp_ready));
        chk("w_in_ready", 32'(w_in_ready), 32'(exp_ready));
        chk("mem_we", 32'(mem_we_o), 32'(exp_we));
        chk("w_mem_we", 32'(w_mem_we), 32'(exp_we));
        chk("err", 32'(err_o), 32'(perr));
        chk("done", 32'(done_o), 32'(pdone));
        chk("instr_cnt", 32'(instr_cnt_o), 32'(cnt_exp));
        chk("wrap", 32'(wrap_o), 32'(writes >= 256));
        chk("w_wrap", 32'(w_wrap), 32'(writes >= WRAP_WORDS));
        if (exp_we) begin
            head = q[0];
            chk("data", mem_data_o, head);
            chk("w_data", w_mem_data, head);
            chk("addr", mem_addr_o, 32'(4 * (writes % 256)));
            chk("w_addr", w_mem_addr, WRAP_BASE + 32'(4 * (writes % WRAP_WORDS)));
            if (mem_wready_i) begin
                $display("t=%0t write addr=%h data=%h cnt=%0d", $time, mem_addr_o, mem_data_o, instr_cnt_o);
                if (lit_q.size() != 0) chk("literal_word", mem_data_o, lit_q.pop_front());
                void'(q.pop_front());
                writes++;
            end
        end
        acc_g = in_valid_i && exp_ready;
        legal = ref_encode(int'(op_sel_i), int'(rs_i), int'(rt_i), int'(rd_i), int'(shamt_i),
                           int'(funct_i), int'(imm_i), int'(target_i), w);
        if (acc_g && legal) q.push_back(w);
        perr  = acc_g && !legal;
        pdone = 0;
        case (mstate)
            0: if (load_start_i) begin mstate = 1; writes = 0; end
            1: if (load_end_i) mstate = 2;
            default: if (was_empty) begin mstate = 0; pdone = 1; end
        endcase
        @(posedge clk);
        #1;
        if (rand_wr) mem_wready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic set_fields(input int op, input int rs, input int rt, input int rd,
                              input int sh, input int fn, input int imm, input int tg);
        op_sel_i = op[3:0];  rs_i = rs[4:0];  rt_i = rt[4:0];  rd_i = rd[4:0];
        shamt_i = sh[4:0];   funct_i = fn[5:0]; imm_i = imm[15:0]; target_i = tg[25:0];
    endtask

    task automatic send(input int op, input int rs, input int rt, input int rd,
                        input int sh, input int fn, input int imm, input int tg);
        set_fields(op, rs, rt, rd, sh, fn, imm, tg);
        in_valid_i = 1'b1;
        acc_g = 0;
        for (int k = 0; k < 60 && !acc_g; k++) cycle();
        in_valid_i = 1'b0;
        $display("t=%0t send op=%0d accepted=%0d", $time, op, acc_g);
        chk("send_accept", 32'(acc_g), 1);
    endtask

    task automatic send_random();
        send($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535), $urandom_range(0, 67108863));
    endtask

    task automatic start_session();
        load_start_i = 1'b1;
        cycle();
        load_start_i = 1'b0;
    endtask

    task automatic end_session();
        int n;
        load_end_i = 1'b1;
        cycle();
        load_end_i = 1'b0;
        n = 0;
        while (mstate != 0 && n < 200) begin
            cycle();
            n++;
        end
        chk("drain_bound", 32'(mstate), 0);
        cycle();
        $display("t=%0t session done writes=%0d", $time, writes);
    endtask

    initial begin
        rst_n = 1'b0;
        load_start_i = 0; load_end_i = 0; in_valid_i = 0; mem_wready_i = 0; rand_wr = 0;
        set_fields(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        cycle();

        // ADDI at the base address, visible the cycle after acceptance
        mem_wready_i = 1'b1;
        start_session();
        lit_q.push_back(32'h2022_0005);
        send(1, 1, 2, 0, 0, 0, 16'h0005, 0);
        repeat (2) cycle();
        end_session();

        // R-type, LUI with rs forced to zero, J
        start_session();
        lit_q.push_back(32'h0022_1820);
        lit_q.push_back(32'h3C05_1234);
        lit_q.push_back(32'h0800_0010);
        send(0, 1, 2, 3, 0, 'h20, 0, 0);
        send(4, 7, 5, 0, 0, 0, 'h1234, 0);
        send(12, 0, 0, 0, 0, 0, 0, 'h10);
        repeat (3) cycle();
        end_session();

        // Illegal classes: handshake completes, err pulse, nothing written; end with empty FIFO
        start_session();
        send(9, 1, 2, 3, 0, 0, 'h55, 0);
        send(14, 3, 4, 5, 0, 0, 'h66, 0);
        repeat (2) cycle();
        end_session();

        // Backpressure: four fill the FIFO, the fifth waits for the memory to drain
        start_session();
        mem_wready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(5, i + 1, i + 2, 0, 0, 0, 'h100 + i, 0);
        set_fields(7, 9, 10, 0, 0, 0, 'h0040, 0);
        in_valid_i = 1'b1;
        repeat (3) cycle();
        mem_wready_i = 1'b1;
        send(7, 9, 10, 0, 0, 0, 'h0040, 0);
        end_session();

        // Random traffic with random memory backpressure and ignored control pulses
        load_end_i = 1'b1;
        cycle();
        load_end_i = 1'b0;
        rand_wr = 1;
        start_session();
        for (int i = 0; i < 40; i++) begin
            send_random();
            repeat ($urandom_range(0, 2)) cycle();
            if (i == 20) begin
                load_start_i = 1'b1;
                cycle();
                load_start_i = 1'b0;
            end
        end
        while (q.size() >= DEPTH) cycle();
        // Final instruction arrives together with load_end and must still be written
        set_fields(13, 0, 0, 0, 0, 0, 0, 'h2AB_CDEF);
        in_valid_i = 1'b1;
        load_end_i = 1'b1;
        cycle();
        chk("accept_with_end", 32'(acc_g), 1);
        in_valid_i = 1'b0;
        load_end_i = 1'b0;
        begin
            int n = 0;
            while (mstate != 0 && n < 300) begin cycle(); n++; end
        end
        chk("rand_drain_bound", 32'(mstate), 0);
        cycle();
        rand_wr = 0;

        // Asynchronous reset in the middle of a drain
        mem_wready_i = 1'b0;
        start_session();
        for (int i = 0; i < 3; i++) send(8, i, i + 1, 0, 0, 0, 'h0200 + i, 0);
        load_end_i = 1'b1;
        cycle();
        load_end_i = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid_drain_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("held_reset");
        rst_n = 1'b1;
        mem_wready_i = 1'b1;
        repeat (4) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
